// File: rtl/baccarat_pkg.sv
// Shared types and constants for the baccarat round controller.
package baccarat_pkg;

  typedef enum logic [3:0] {
    DEAL_P1 = 4'd0,
    DEAL_D1 = 4'd1,
    DEAL_P2 = 4'd2,
    DEAL_D2 = 4'd3,
    CHECK   = 4'd4,
    P3      = 4'd5,
    BDEC    = 4'd6,
    D3      = 4'd7,
    DONE    = 4'd8
  } ctrl_state_t;

  localparam logic [3:0] NATURAL_MIN      = 4'd8;
  localparam logic [3:0] PLAYER_STAND_MIN = 4'd6;

  // Tens and court cards count as zero.
  function automatic logic [3:0] face_value(input logic [3:0] rank);
    return (rank >= 4'd10) ? 4'd0 : rank;
  endfunction

endpackage

// File: rtl/baccarat_ctrl_draw_rules.sv
// Banker third-card table: decides whether the banker draws once the player has drawn.
module baccarat_draw_rules
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       banker_draw
);

  logic [3:0] w_face;

  always_comb begin
    w_face      = face_value(pcard3);
    banker_draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: banker_draw = 1'b1;
      4'd3:             banker_draw = (w_face != 4'd8);
      4'd4:             banker_draw = (w_face >= 4'd2) && (w_face <= 4'd7);
      4'd5:             banker_draw = (w_face >= 4'd4) && (w_face <= 4'd7);
      4'd6:             banker_draw = (w_face >= 4'd6) && (w_face <= 4'd7);
      default:          banker_draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/baccarat_ctrl.sv
// Baccarat round sequencer: deals cards via load strobes, applies drawing rules, reports winner.
// Optional BACCARAT_STATS_EN adds saturating per-side win counters.
module baccarat_ctrl
  import baccarat_pkg::*;
(
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win,
  output logic       dealer_win
`ifdef BACCARAT_STATS_EN
  ,
  output logic [7:0] player_wins,
  output logic [7:0] dealer_wins
`endif
);

  ctrl_state_t r_state;
  ctrl_state_t w_next;
  // Strobe order: {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3}
  logic [5:0]  w_load;
  logic        w_pwin;
  logic        w_dwin;
  logic        w_banker_draw;

  baccarat_draw_rules u_draw_rules (
    .dscore      (dscore),
    .pcard3      (pcard3),
    .banker_draw (w_banker_draw)
  );

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) r_state <= DEAL_P1;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 6'b000000;
    w_pwin = 1'b0;
    w_dwin = 1'b0;
    case (r_state)
      DEAL_P1: begin w_load = 6'b100000; w_next = DEAL_D1; end
      DEAL_D1: begin w_load = 6'b000100; w_next = DEAL_P2; end
      DEAL_P2: begin w_load = 6'b010000; w_next = DEAL_D2; end
      DEAL_D2: begin w_load = 6'b000010; w_next = CHECK;   end
      CHECK: begin
        if ((pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN)) w_next = DONE;
        else if (pscore < PLAYER_STAND_MIN)                     w_next = P3;
        else if (dscore < PLAYER_STAND_MIN)                     w_next = D3;
        else                                                    w_next = DONE;
      end
      P3:   begin w_load = 6'b001000; w_next = BDEC; end
      BDEC: w_next = w_banker_draw ? D3 : DONE;
      D3:   begin w_load = 6'b000001; w_next = DONE; end
      DONE: begin
        w_pwin = (pscore >= dscore);
        w_dwin = (dscore >= pscore);
      end
      default: w_next = DEAL_P1;
    endcase
  end

  // Reset masks every output immediately, independent of the registered state.
  assign load_pcard1 = resetb & w_load[5];
  assign load_pcard2 = resetb & w_load[4];
  assign load_pcard3 = resetb & w_load[3];
  assign load_dcard1 = resetb & w_load[2];
  assign load_dcard2 = resetb & w_load[1];
  assign load_dcard3 = resetb & w_load[0];
  assign player_win  = resetb & w_pwin;
  assign dealer_win  = resetb & w_dwin;

`ifdef BACCARAT_STATS_EN
  logic [7:0] r_player_wins;
  logic [7:0] r_dealer_wins;
  logic       r_done_seen;

  // Counts only on the first DONE cycle of each round.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      r_player_wins <= 8'd0;
      r_dealer_wins <= 8'd0;
      r_done_seen   <= 1'b0;
    end else if ((r_state == DONE) && !r_done_seen) begin
      r_done_seen <= 1'b1;
      if (w_pwin && (r_player_wins != 8'hFF)) r_player_wins <= r_player_wins + 8'd1;
      if (w_dwin && (r_dealer_wins != 8'hFF)) r_dealer_wins <= r_dealer_wins + 8'd1;
    end
  end

  assign player_wins = r_player_wins;
  assign dealer_wins = r_dealer_wins;
`endif

endmodule

// File: tb/tb_baccarat_ctrl.sv
// Self-checking bench for baccarat_ctrl: the bench plays the datapath and predicts each round.
module tb_baccarat_ctrl;

  logic       slow_clock = 1'b0;
  logic       resetb;
  logic [3:0] pscore, dscore, pcard3;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win, dealer_win;
`ifdef BACCARAT_STATS_EN
  logic [7:0] player_wins, dealer_wins;
`endif

  baccarat_ctrl dut (
    .slow_clock  (slow_clock),
    .resetb      (resetb),
    .pscore      (pscore),
    .dscore      (dscore),
    .pcard3      (pcard3),
    .load_pcard1 (load_pcard1),
    .load_pcard2 (load_pcard2),
    .load_pcard3 (load_pcard3),
    .load_dcard1 (load_dcard1),
    .load_dcard2 (load_dcard2),
    .load_dcard3 (load_dcard3),
    .player_win  (player_win),
    .dealer_win  (dealer_win)
`ifdef BACCARAT_STATS_EN
    ,
    .player_wins (player_wins),
    .dealer_wins (dealer_wins)
`endif
  );

  always #5 slow_clock = ~slow_clock;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         ld_p[3];
  int         ld_d[3];
  logic [7:0] exp_q[$];

  // Expected-vector layout: {player_win, dealer_win, lp1, lp2, lp3, ld1, ld2, ld3}
  localparam logic [7:0] E_P1 = 8'b00_100_000;
  localparam logic [7:0] E_P2 = 8'b00_010_000;
  localparam logic [7:0] E_P3 = 8'b00_001_000;
  localparam logic [7:0] E_D1 = 8'b00_000_100;
  localparam logic [7:0] E_D2 = 8'b00_000_010;
  localparam logic [7:0] E_D3 = 8'b00_000_001;
  localparam logic [7:0] E_NO = 8'b00_000_000;

  function automatic int fv(input int r);
    return (r >= 10) ? 0 : r;
  endfunction

  function automatic bit banker_rule(input int d, input int f);
    if (d <= 2) return 1'b1;
    if (d == 3) return f != 8;
    if (d == 4) return (f >= 2) && (f <= 7);
    if (d == 5) return (f >= 4) && (f <= 7);
    if (d == 6) return (f >= 6) && (f <= 7);
    return 1'b0;
  endfunction

  function automatic logic [7:0] outs();
    return {player_win, dealer_win, load_pcard1, load_pcard2, load_pcard3,
            load_dcard1, load_dcard2, load_dcard3};
  endfunction

  // Whole-round prediction from the six cards {p1, d1, p2, d2, p3, d3}.
  task automatic build(input int c[6]);
    int p, d, f;
    bit pdraw, bdraw;
    exp_q.delete();
    p = (fv(c[0]) + fv(c[2])) % 10;
    d = (fv(c[1]) + fv(c[3])) % 10;
    exp_q.push_back(E_P1); exp_q.push_back(E_D1);
    exp_q.push_back(E_P2); exp_q.push_back(E_D2);
    exp_q.push_back(E_NO);
    pdraw = 1'b0;
    bdraw = 1'b0;
    if (p < 8 && d < 8) begin
      if (p <= 5) begin
        pdraw = 1'b1;
        f = fv(c[4]);
        bdraw = banker_rule(d, f);
        p = (p + f) % 10;
      end else begin
        bdraw = (d <= 5);
      end
    end
    if (pdraw) begin exp_q.push_back(E_P3); exp_q.push_back(E_NO); end
    if (bdraw) begin exp_q.push_back(E_D3); d = (d + fv(c[5])) % 10; end
    repeat (3) exp_q.push_back({(p >= d), (d >= p), 6'b000000});
  endtask

  task automatic update_scores();
    pscore = 4'((fv(ld_p[0]) + fv(ld_p[1]) + fv(ld_p[2])) % 10);
    dscore = 4'((fv(ld_d[0]) + fv(ld_d[1]) + fv(ld_d[2])) % 10);
    pcard3 = 4'(ld_p[2]);
  endtask

  task automatic clear_cards();
    for (int i = 0; i < 3; i++) begin ld_p[i] = 0; ld_d[i] = 0; end
    update_scores();
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Entered with resetb low just after a falling edge; exits the same way.
  task automatic run_round(input string name, input int c[6], input int abort_at);
    logic [7:0] e, o;
    int epc, edc;
    bit seen;
    epc = 0; edc = 0; seen = 1'b0;
    build(c);
    resetb = 1'b1;
    #1;
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      o = outs();
      check($sformatf("%s cyc%0d", name, i), o, e);
`ifdef BACCARAT_STATS_EN
      if (e[7] | e[6]) begin
        check($sformatf("%s pcnt%0d", name, i), player_wins, 8'(epc));
        check($sformatf("%s dcnt%0d", name, i), dealer_wins, 8'(edc));
        if (!seen) begin epc += int'(e[7]); edc += int'(e[6]); seen = 1'b1; end
      end
`else
      if ((e[7] | e[6]) && !seen) begin epc++; edc++; seen = 1'b1; end
`endif
      if (i == abort_at) begin
        resetb = 1'b0;
        #1;
        check($sformatf("%s midreset", name), outs(), 8'h00);
`ifdef BACCARAT_STATS_EN
        check($sformatf("%s midreset cnt", name), {player_wins[3:0], dealer_wins[3:0]}, 8'h00);
`endif
        break;
      end
      @(posedge slow_clock);
      #1;
      if (o[5]) ld_p[0] = c[0];
      if (o[2]) ld_d[0] = c[1];
      if (o[4]) ld_p[1] = c[2];
      if (o[1]) ld_d[1] = c[3];
      if (o[3]) ld_p[2] = c[4];
      if (o[0]) ld_d[2] = c[5];
      update_scores();
      @(negedge slow_clock);
      #1;
    end
    resetb = 1'b0;
    clear_cards();
    #1;
    check($sformatf("%s endreset", name), outs(), 8'h00);
    @(negedge slow_clock);
  endtask

  initial begin
    int c[6];
    resetb = 1'b0;
    clear_cards();
    repeat (2) @(negedge slow_clock);
    #1;
    check("reset_state", outs(), 8'h00);
`ifdef BACCARAT_STATS_EN
    check("reset_cnt", {player_wins[3:0], dealer_wins[3:0]}, 8'h00);
`endif
    @(negedge slow_clock);

    c = '{3, 1, 5, 1, 7, 7};   run_round("natural", c, -1);
    c = '{2, 3, 2, 3, 6, 5};   run_round("pdraw_bdraw", c, -1);
    c = '{13, 10, 6, 3, 1, 4}; run_round("pstand_bdraw", c, -1);
    c = '{1, 1, 2, 2, 12, 5};  run_round("face_q", c, -1);
    c = '{1, 1, 2, 2, 8, 5};   run_round("edge_8", c, -1);
    c = '{3, 3, 4, 4, 9, 9};   run_round("tie", c, -1);
    c = '{2, 3, 2, 3, 6, 5};   run_round("abort_p3", c, 5);
    c = '{2, 3, 2, 3, 6, 5};   run_round("after_abort", c, -1);

    for (int r = 0; r < 60; r++) begin
      for (int j = 0; j < 6; j++) c[j] = int'($urandom_range(1, 13));
      run_round($sformatf("rand%0d", r), c, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
